// File: rtl/vedic_mult_seq.sv
// Sequential unsigned WIDTH x WIDTH multiplier built on one shared
// half-width vedic_mult; four partial products accumulate over 4 cycles.
//
// vedic_mult_seq ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, a, b      : operand handshake
//   out_valid/out_ready, out     : product handshake (2*WIDTH bits)
//   busy                         : high whenever not IDLE
// vedic_mult ports:
//   a, b (W bits) -> p (2*W bits), purely combinational

module vedic_mult #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  localparam int H = W / 2;

  if (W == 2) begin : g_base
    logic t0, t1, c;
    assign t0   = a[1] & b[0];
    assign t1   = a[0] & b[1];
    assign c    = t0 & t1;
    assign p[0] = a[0] & b[0];
    assign p[1] = t0 ^ t1;
    assign p[2] = (a[1] & b[1]) ^ c;
    assign p[3] = a[1] & b[1] & c;
  end else begin : g_rec
    logic [W-1:0] ll, lh, hl, hh;

    vedic_mult #(.W(H)) u_ll (
      .a(a[H-1:0]), .b(b[H-1:0]), .p(ll)
    );
    vedic_mult #(.W(H)) u_lh (
      .a(a[H-1:0]), .b(b[W-1:H]), .p(lh)
    );
    vedic_mult #(.W(H)) u_hl (
      .a(a[W-1:H]), .b(b[H-1:0]), .p(hl)
    );
    vedic_mult #(.W(H)) u_hh (
      .a(a[W-1:H]), .b(b[W-1:H]), .p(hh)
    );

    // cross terms sit at shift H inside the 2W result
    assign p = {hh, ll}
             + {{H{1'b0}}, lh, {H{1'b0}}}
             + {{H{1'b0}}, hl, {H{1'b0}}};
  end

endmodule

module vedic_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int H = WIDTH / 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         step;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;

  logic [H-1:0]       op_a;
  logic [H-1:0]       op_b;
  logic [WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0] addend;
  logic               is_idle;
  logic               is_done;
  logic               accept;

  assign is_idle   = (state == S_IDLE);
  assign is_done   = (state == S_DONE);
  assign in_ready  = is_idle | (is_done & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = is_done;
  assign out       = acc;
  assign busy      = ~is_idle;

  // step[1] picks the a half, step[0] the b half
  assign op_a = step[1] ? a_q[WIDTH-1:H] : a_q[H-1:0];
  assign op_b = step[0] ? b_q[WIDTH-1:H] : b_q[H-1:0];

  vedic_mult #(.W(H)) u_mult (
    .a(op_a),
    .b(op_b),
    .p(pp)
  );

  always_comb begin
    addend = '0;
    unique case (step)
      2'd0:    addend = {{WIDTH{1'b0}}, pp};
      2'd3:    addend = {pp, {WIDTH{1'b0}}};
      default: addend = {{H{1'b0}}, pp, {H{1'b0}}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      step  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
    end else begin
      unique case (1'b1)
        (state == S_MUL): begin
          acc  <= acc + addend;
          step <= step + 2'd1;
          if (step == 2'd3)
            state <= S_DONE;
        end
        is_done && out_ready && !in_valid: begin
          state <= S_IDLE;
        end
        accept: begin
          a_q   <= a;
          b_q   <= b;
          acc   <= '0;
          step  <= '0;
          state <= S_MUL;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed bench for vedic_mult_seq at WIDTH=8 and WIDTH=16.
// Hand-computed products, latency, backpressure, back-to-back, reset.

module tb_vedic_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;

  logic        iv16, ir16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] out16;

  int vectors = 0;
  int miscompares = 0;

  vedic_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8),
    .out(out8), .busy(busy8)
  );

  vedic_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16),
    .out(out16), .busy(busy16)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // accept at edge T, then result must appear after exactly 4 more edges
  task automatic op8(input string tag, input logic [7:0] x,
                     input logic [7:0] y, input logic [15:0] e);
    a8 = x; b8 = y; iv8 = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(ir8), 32'd1);
    tick;
    iv8 = 1'b0; a8 = 8'h5a; b8 = 8'hc3;
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk({tag, "_early"}, 32'(ov8), 32'd0);
    end
    tick;
    chk({tag, "_ov"}, 32'(ov8), 32'd1);
    chk({tag, "_out"}, 32'(out8), 32'(e));
  endtask

  task automatic drain8(input string tag);
    or8 = 1'b1;
    #1 chk({tag, "_ir_drain"}, 32'(ir8), 32'd1);
    tick;
    or8 = 1'b0;
    chk({tag, "_ov_drop"}, 32'(ov8), 32'd0);
    chk({tag, "_idle"}, 32'(busy8), 32'd0);
  endtask

  task automatic op16(input string tag, input logic [15:0] x,
                      input logic [15:0] y, input logic [31:0] e);
    a16 = x; b16 = y; iv16 = 1'b1;
    tick;
    iv16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk({tag, "_early"}, 32'(ov16), 32'd0);
    end
    tick;
    chk({tag, "_ov"}, 32'(ov16), 32'd1);
    chk({tag, "_out"}, out16, e);
    or16 = 1'b1;
    tick;
    or16 = 1'b0;
    chk({tag, "_drop"}, 32'(ov16), 32'd0);
  endtask

  initial begin
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0;

    tick;
    tick;
    rst = 1'b0;
    chk("rst_ov", 32'(ov8), 32'd0);
    chk("rst_out", 32'(out8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_ir", 32'(ir8), 32'd1);

    op8("ffxff", 8'hff, 8'hff, 16'hfe01);
    chk("ffxff_ir_hold", 32'(ir8), 32'd0);
    drain8("ffxff");
    chk("ffxff_ir_idle", 32'(ir8), 32'd1);

    op8("a5x3c", 8'ha5, 8'h3c, 16'h26ac);
    or8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a8 = 8'h11; b8 = 8'h22; iv8 = (i % 2) == 0;
      #1 chk("bp_ir", 32'(ir8), 32'd0);
      tick;
      chk("bp_ov", 32'(ov8), 32'd1);
      chk("bp_out", 32'(out8), 32'h26ac);
    end
    iv8 = 1'b0;
    drain8("bp");
    chk("bp_out_keep", 32'(out8), 32'h26ac);
    tick;
    chk("bp_single", 32'(ov8), 32'd0);

    op8("00x7f", 8'h00, 8'h7f, 16'h0000);
    drain8("00x7f");

    op8("b2b_first", 8'ha5, 8'h3c, 16'h26ac);
    a8 = 8'h12; b8 = 8'h34; iv8 = 1'b1; or8 = 1'b1;
    #1 chk("b2b_ir", 32'(ir8), 32'd1);
    tick;
    iv8 = 1'b0; or8 = 1'b0;
    chk("b2b_ov_drop", 32'(ov8), 32'd0);
    chk("b2b_busy", 32'(busy8), 32'd1);
    chk("b2b_acc_clr", 32'(out8), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("b2b_early", 32'(ov8), 32'd0);
    end
    tick;
    chk("b2b_ov", 32'(ov8), 32'd1);
    chk("b2b_out", 32'(out8), 32'h03a8);
    drain8("b2b");

    a8 = 8'hff; b8 = 8'hff; iv8 = 1'b1;
    tick;
    iv8 = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_ov", 32'(ov8), 32'd0);
    chk("mrst_out", 32'(out8), 32'd0);
    chk("mrst_busy", 32'(busy8), 32'd0);
    chk("mrst_ir", 32'(ir8), 32'd1);
    tick;
    chk("mrst_no_out", 32'(ov8), 32'd0);
    op8("03x05", 8'h03, 8'h05, 16'h000f);
    drain8("03x05");

    op16("w16_ffff", 16'hffff, 16'hffff, 32'hfffe0001);
    op16("w16_1234", 16'h1234, 16'h5678, 32'h06260060);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
